// File: rtl/store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_unit_pkg
// Brief    : Store opcodes and lane-strobe helper shared by the store path.
// Revision : 1.0
// ============================================================================
package store_unit_pkg;

    localparam int STORE_OP_WIDTH = 3;

    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 3'b000;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 3'b001;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 3'b010;

    // Unshifted strobe for an op; all-zero marks an illegal funct3.
    function automatic logic [3:0] store_base_strb(input logic [STORE_OP_WIDTH-1:0] funct3);
        logic [3:0] strb;
        strb = 4'b0000;
        case (funct3)
            STORE_OP_SB: strb = 4'b0001;
            STORE_OP_SH: strb = 4'b0011;
            STORE_OP_SW: strb = 4'b1111;
            default:     strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : store_unit_if
// Brief    : Request, memory-write and response signals of the store unit.
// Revision : 1.0
// ============================================================================
interface store_unit_if;
    import store_unit_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [STORE_OP_WIDTH-1:0] req_funct3;
    logic [31:0]               req_addr;
    logic [31:0]               req_data;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wstrb;

    logic                      resp_valid;
    logic                      resp_error;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output resp_valid, resp_error
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  resp_valid, resp_error
    );

endinterface
`default_nettype wire

// File: rtl/store_unit_aligner.sv
`default_nettype none
// ============================================================================
// Module   : store_aligner
// Brief    : Combinational decode of a store into an 8-lane strobe and data.
// Revision : 1.0
// ============================================================================
module store_aligner
    import store_unit_pkg::*;
(
    input  wire logic [STORE_OP_WIDTH-1:0] funct3,
    input  wire logic [1:0]                offset,
    input  wire logic [31:0]               data,
    output logic                           legal,
    output logic                           misaligned,
    output logic [7:0]                     strobe,
    output logic [63:0]                    shifted_data
);

    logic [3:0] base_strb;

    always_comb begin
        base_strb    = store_base_strb(funct3);
        legal        = |base_strb;
        // base_strb[2:1] equals width-1 (00/01/11), i.e. the alignment mask.
        misaligned   = |(offset & base_strb[2:1]);
        strobe       = {4'b0000, base_strb} << offset;
        shifted_data = {32'h0000_0000, data} << {offset, 3'b000};
    end

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_unit
// Brief    : Store FSM driving word-aligned strobed writes, splitting crossers.
// Revision : 1.0
// ============================================================================
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    store_unit_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BEAT0 = ST_BEAT0,
        BEAT1 = ST_BEAT1,
        RESP  = ST_RESP
    } state_t;

    state_t      state_q,    state_d;
    logic        err_q,      err_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  wstrb_q,    wstrb_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]  hi_wstrb_q, hi_wstrb_d;

    logic        al_legal;
    logic        al_misaligned;
    logic [7:0]  al_strobe;
    logic [63:0] al_data;

    store_aligner u_aligner (
        .funct3       (bus.req_funct3),
        .offset       (bus.req_addr[1:0]),
        .data         (bus.req_data),
        .legal        (al_legal),
        .misaligned   (al_misaligned),
        .strobe       (al_strobe),
        .shifted_data (al_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            hi_wdata_q <= 32'h0000_0000;
            hi_wstrb_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            hi_wdata_q <= hi_wdata_d;
            hi_wstrb_q <= hi_wstrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        hi_wdata_d = hi_wdata_q;
        hi_wstrb_d = hi_wstrb_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!al_legal || (!MISALIGN_SPLIT && al_misaligned)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = BEAT0;
                        err_d      = 1'b0;
                        addr_d     = {bus.req_addr[31:2], 2'b00};
                        wstrb_d    = al_strobe[3:0];
                        wdata_d    = al_data[31:0];
                        hi_wstrb_d = al_strobe[7:4];
                        hi_wdata_d = al_data[63:32];
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (|hi_wstrb_q) begin
                        // Output registers advance to the second word so the
                        // beat stays glitch-free and mem_valid never drops.
                        state_d = BEAT1;
                        addr_d  = addr_q + 32'd4;
                        wstrb_d = hi_wstrb_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_valid  = (state_q == BEAT0) || (state_q == BEAT1);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wstrb  = wstrb_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_error = err_q && (state_q == RESP);

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_unit
// Brief    : Scoreboarded directed bench for store_unit (split and no-split).
// Revision : 1.0
// ============================================================================
module tb_store_unit;
    import store_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        err;
        int unsigned cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        resetn;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          stall_a = 0;
    int          wait_cnt = 0;

    beat_t bq_a[$];
    resp_t rq_a[$];
    resp_t rq_b[$];

    store_unit_if ifa ();
    store_unit_if ifb ();

    store_unit #(.MISALIGN_SPLIT(1'b1)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));
    store_unit #(.MISALIGN_SPLIT(1'b0)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory side for dut_a: ready after stall_a wait states per beat.
    always begin
        @(posedge clk);
        #2;
        if (ifa.mem_valid) begin
            if (wait_cnt >= stall_a) begin
                ifa.mem_ready = 1'b1;
                wait_cnt      = 0;
            end else begin
                ifa.mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            ifa.mem_ready = 1'b0;
            wait_cnt      = 0;
        end
    end

    // Monitor: compares every presented beat and response against the queues.
    always @(negedge clk) begin : monitor
        beat_t e;
        resp_t r;
        logic  ok;
        if (ifa.mem_valid) begin
            checks++;
            if (bq_a.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got addr=%h strb=%b data=%h, required no beat",
                         ifa.mem_addr, ifa.mem_wstrb, ifa.mem_wdata);
            end else begin
                e  = bq_a[0];
                ok = (ifa.mem_addr == e.addr) && (ifa.mem_wstrb == e.strb);
                for (int i = 0; i < 4; i++) begin
                    if (e.strb[i] && (ifa.mem_wdata[8*i +: 8] != e.data[8*i +: 8])) ok = 1'b0;
                end
                if (!ok) begin
                    errors++;
                    $display("FAIL beat: got addr=%h strb=%b data=%h, required addr=%h strb=%b data=%h",
                             ifa.mem_addr, ifa.mem_wstrb, ifa.mem_wdata, e.addr, e.strb, e.data);
                end
                if (ifa.mem_ready) void'(bq_a.pop_front());
            end
        end
        if (ifa.resp_valid) begin
            checks++;
            if (rq_a.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected_a: got err=%b at cycle %0d, required none", ifa.resp_error, cyc);
            end else begin
                r = rq_a.pop_front();
                if (ifa.resp_error != r.err || cyc != r.cyc) begin
                    errors++;
                    $display("FAIL resp_a: got err=%b cycle=%0d, required err=%b cycle=%0d",
                             ifa.resp_error, cyc, r.err, r.cyc);
                end
            end
        end
        if (ifb.mem_valid) begin
            checks++;
            errors++;
            $display("FAIL b_mem_valid: got mem_valid=1, required 0");
        end
        if (ifb.resp_valid) begin
            checks++;
            if (rq_b.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected_b: got err=%b, required none", ifb.resp_error);
            end else begin
                r = rq_b.pop_front();
                if (ifb.resp_error != r.err || cyc != r.cyc) begin
                    errors++;
                    $display("FAIL resp_b: got err=%b cycle=%0d, required err=%b cycle=%0d",
                             ifb.resp_error, cyc, r.err, r.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        beat_t b;
        b.addr = addr;
        b.strb = strb;
        b.data = data;
        bq_a.push_back(b);
    endtask

    // Issue one request on dut_a (on_b=0) or dut_b (on_b=1) and, if wanted,
    // wait until the scoreboard has drained.
    task automatic issue(input bit on_b, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int stall, input bit want_resp,
                         input logic err, input int lat);
        resp_t r;
        int    n;
        logic  rdy;
        @(negedge clk);
        stall_a = stall;
        if (on_b) begin
            ifb.req_valid = 1'b1; ifb.req_funct3 = f3; ifb.req_addr = addr; ifb.req_data = data;
        end else begin
            ifa.req_valid = 1'b1; ifa.req_funct3 = f3; ifa.req_addr = addr; ifa.req_data = data;
        end
        n   = 0;
        rdy = on_b ? ifb.req_ready : ifa.req_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = on_b ? ifb.req_ready : ifa.req_ready;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0, required 1");
        end
        if (want_resp) begin
            r.err = err;
            r.cyc = cyc + lat;
            if (on_b) rq_b.push_back(r);
            else      rq_a.push_back(r);
        end
        @(posedge clk);
        #1;
        // Inputs scrambled after acceptance must not affect the transaction.
        if (on_b) begin
            ifb.req_valid = 1'b0; ifb.req_funct3 = 3'b111; ifb.req_addr = ~addr; ifb.req_data = ~data;
        end else begin
            ifa.req_valid = 1'b0; ifa.req_funct3 = 3'b111; ifa.req_addr = ~addr; ifa.req_data = ~data;
        end
        if (want_resp) begin
            n = 0;
            while ((rq_a.size() != 0 || rq_b.size() != 0 || bq_a.size() != 0) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got pending beats=%0d resps=%0d, required 0",
                         bq_a.size(), rq_a.size() + rq_b.size());
                bq_a.delete(); rq_a.delete(); rq_b.delete();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        ifa.req_valid = 1'b0; ifa.req_funct3 = '0; ifa.req_addr = '0; ifa.req_data = '0; ifa.mem_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_funct3 = '0; ifb.req_addr = '0; ifb.req_data = '0; ifb.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'h0, ifa.req_ready},  32'h1);
        chk("rst_mem_valid",  {31'h0, ifa.mem_valid},  32'h0);
        chk("rst_mem_addr",   ifa.mem_addr,            32'h0);
        chk("rst_mem_wdata",  ifa.mem_wdata,           32'h0);
        chk("rst_mem_wstrb",  {28'h0, ifa.mem_wstrb},  32'h0);
        chk("rst_resp",       {30'h0, ifa.resp_valid, ifa.resp_error}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        push_beat(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        issue(1'b0, STORE_OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 2);

        push_beat(32'h0000_0200, 4'b1000, 32'hA500_0000);
        issue(1'b0, STORE_OP_SB, 32'h0000_0203, 32'h0000_00A5, 0, 1'b1, 1'b0, 2);

        push_beat(32'h0000_0200, 4'b1100, 32'h1234_0000);
        issue(1'b0, STORE_OP_SH, 32'h0000_0202, 32'hABCD_1234, 0, 1'b1, 1'b0, 2);

        push_beat(32'h0000_0200, 4'b0110, 32'h0056_7800);
        issue(1'b0, STORE_OP_SH, 32'h0000_0201, 32'h0000_5678, 0, 1'b1, 1'b0, 2);

        push_beat(32'h0000_0100, 4'b1110, 32'h2233_4400);
        push_beat(32'h0000_0104, 4'b0001, 32'h0000_0011);
        issue(1'b0, STORE_OP_SW, 32'h0000_0101, 32'h1122_3344, 3, 1'b1, 1'b0, 9);

        push_beat(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        push_beat(32'h0000_0000, 4'b0001, 32'h0000_00BE);
        issue(1'b0, STORE_OP_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 1, 1'b1, 1'b0, 5);

        issue(1'b0, 3'b011,      32'h0000_0100, 32'h1111_1111, 0, 1'b1, 1'b1, 1);
        issue(1'b1, STORE_OP_SW, 32'h0000_0102, 32'h2222_2222, 0, 1'b1, 1'b1, 1);

        push_beat(32'h0000_0100, 4'b1100, 32'hF00D_0000);
        push_beat(32'h0000_0104, 4'b0011, 32'h0000_CAFE);
        issue(1'b0, STORE_OP_SW, 32'h0000_0102, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 0);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (bq_a.size() != 1 && n < 40);
        chk("reach_beat1", bq_a.size(), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_mem_valid", {31'h0, ifa.mem_valid}, 32'h0);
        chk("arst_req_ready", {31'h0, ifa.req_ready}, 32'h1);
        chk("arst_mem_wstrb", {28'h0, ifa.mem_wstrb}, 32'h0);
        chk("arst_resp",      {31'h0, ifa.resp_valid}, 32'h0);
        bq_a.delete();
        @(negedge clk);
        resetn = 1'b1;

        push_beat(32'h0000_0300, 4'b1111, 32'h0102_0304);
        issue(1'b0, STORE_OP_SW, 32'h0000_0300, 32'h0102_0304, 0, 1'b1, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_unit.md
# store_unit

Store-side counterpart of the load path in the kianv multicycle rv32im core. Accepts one store request per transaction (funct3, byte address, rs2 data) and drives a word-aligned memory write with byte strobes. Stores that cross a word boundary are split into two bus beats when enabled; otherwise they are rejected. Completion or error is reported back to the control FSM with a one-cycle response pulse.

## Interface
- `MISALIGN_SPLIT`, default 1: 1 splits word-crossing stores into two beats; 0 rejects any store not naturally aligned.
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_funct3`  in  3  RISC-V store funct3: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_data`  in  32  rs2 value; SB uses [7:0], SH uses [15:0].
- `mem_valid`  out  1  write beat valid.
- `mem_ready`  in  1  memory accepts the current beat.
- `mem_addr`  out  32  word-aligned address; [1:0] always 00.
- `mem_wdata`  out  32  lane-shifted write data.
- `mem_wstrb`  out  4  byte enables; bit i enables lane i (bits [8i+7:8i]).
- `resp_valid`  out  1  one-cycle pulse: transaction finished.
- `resp_error`  out  1  qualified by `resp_valid`; 1 means illegal funct3 or rejected misalignment.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: `req_ready`=1. On `req_valid`: decode `req_funct3` and compute width W (1/2/4 bytes) and offset k = `req_addr`[1:0].
  - If funct3 is illegal, or `MISALIGN_SPLIT`=0 and k is not a multiple of W: go to RESP with error=1. No memory traffic.
  - Otherwise compute 8-bit strobe S = ((1<<W)-1) << k and 64-bit data D = zero-extend(`req_data`) << 8k. Latch S, D and base = {`req_addr`[31:2],2'b00}, then go to BEAT0.
- BEAT0: drive `mem_valid`=1, `mem_addr`=base, `mem_wstrb`=S[3:0], `mem_wdata`=D[31:0]. On `mem_ready`: go to BEAT1 if S[7:4]≠0, else go to RESP with error=0.
- BEAT1: drive `mem_addr`=base+4 (wraps modulo 2^32), `mem_wstrb`=S[7:4], `mem_wdata`=D[63:32]. On `mem_ready`: go to RESP with error=0.
- RESP: `resp_valid`=1 and `resp_error`=latched error for exactly one cycle, then IDLE.
- Lanes with strobe 0 carry unspecified data. The bench checks only the enabled lanes.
- SB never splits. SH splits only at k=3. SW splits at any k≠0.

## Timing
- All outputs are registered or decoded directly from state. There is no combinational path from request or memory inputs to outputs.
- Reset values: `req_ready`=1 (IDLE), `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `resp_valid`=0, `resp_error`=0.
- Accept at edge 0 → `mem_valid` high from cycle 1. `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_valid`=1 and `mem_ready`=0; unlimited wait states.
- If `mem_ready` is high in cycle 1, a single-beat store raises `resp_valid` in cycle 2 and `req_ready` returns in cycle 3.
- A split store adds exactly one cycle per beat beyond wait states. `mem_valid` stays high continuously across BEAT0→BEAT1.
- Error path: accept at edge 0 → `resp_valid`=1, `resp_error`=1 in cycle 1. `mem_valid` never asserts.
- Request inputs are sampled only on the accept edge; later changes are ignored.
- Asynchronous reset mid-transaction forces IDLE and clears all outputs immediately. A completed BEAT0 of a split store is not rolled back; the response is lost.

## Structure
- `riscv_defines.vh` gains `STORE_OP_WIDTH` and `STORE_OP_SB`, `STORE_OP_SH`, `STORE_OP_SW`, mirroring the existing LOAD_OP set.
- State encodings are localparams inside `store_unit`.
- Sub-module `store_aligner` (combinational):
  - inputs: funct3, offset, data;
  - outputs: legal, misaligned, 8-bit strobe, 64-bit shifted data.
- `store_unit` holds the FSM and the output registers.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, `mem_ready` tied 1 → one beat at 0x100, strb 1111, wdata 0xDEADBEEF; `resp_valid` in cycle 2, error 0.
- SB at 0x203, data 0x000000A5 → addr 0x200, strb 1000, wdata[31:24]=0xA5. SH at 0x202, data 0x1234 → strb 1100, wdata[31:16]=0x1234.
- Split SW at 0x101, data 0x11223344, `mem_ready` low 3 cycles per beat:
  - beat 0: addr 0x100, strb 1110, lanes 1–3 = 44,33,22, held stable through the stall;
  - beat 1: addr 0x104, strb 0001, lane 0 = 0x11.
- SH at 0xFFFFFFFF → beat 0: addr 0xFFFFFFFC, strb 1000. Beat 1: addr 0x00000000, strb 0001.
- funct3=011; and, with `MISALIGN_SPLIT`=0, SW at 0x102 → `resp_valid`=1, `resp_error`=1 in cycle 1. `mem_valid` stays 0.
- `resetn` pulsed low during BEAT1 stall → `mem_valid`=0 and `req_ready`=1 immediately. The next SW completes normally.
